// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave memory model used as the bus target in the AHB
// verification environment. It accepts pipelined address/data-phase transfers,
// writes byte lanes little-endian, inserts WAIT_STATES wait cycles in every
// OKAY data phase, and answers illegal accesses with the two-cycle ERROR.
//
// Optional feature: define AHB_SLV_BURST_CHK_EN to track the expected next
// burst address. A SEQ beat that does not continue the previous transfer then
// takes the ERROR path.
//
// Ports:
//   HCLK       bus clock, rising edge
//   HRESET     asynchronous active-high reset
//   hselect    slave select from the decoder
//   hready     bus-wide ready; gates the address phase
//   htrans     IDLE/BUSY/NONSEQ/SEQ
//   haddr      byte address (AW bits)
//   hwrite     1 = write
//   hsize      log2 of transfer byte count
//   hburst     burst type (used only with AHB_SLV_BURST_CHK_EN)
//   hwdata     write data, valid in the data phase
//   hreadyout  slave ready (registered)
//   hresp      00 OKAY, 01 ERROR (registered)
//   hrdata     read data, zero outside read data phases (registered)
module ahb_slave_mem #(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          hselect,
  input  logic          hready,
  input  logic [1:0]    htrans,
  input  logic [AW-1:0] haddr,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [DW-1:0] hwdata,
  output logic          hreadyout,
  output logic [1:0]    hresp,
  output logic [DW-1:0] hrdata
);

  localparam int NB  = DW / 8;
  localparam int LB  = $clog2(NB);
  localparam int LBW = (LB > 0) ? LB : 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]     WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [LBW-1:0] LANE_MASK = LBW'(NB - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Byte lanes touched by a transfer of 2**size bytes starting at lane.
  function automatic logic [NB-1:0] lane_enables(input logic [2:0] size, input logic [LBW-1:0] lane);
    logic [NB-1:0] en;
    for (int i = 0; i < NB; i++) begin
      en[i] = (i >= int'(lane)) && (i < int'(lane) + (32'sd1 << size));
    end
    return en;
  endfunction

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [NB-1:0] en);
    logic [DW-1:0] res;
    for (int i = 0; i < NB; i++) begin
      res[8*i +: 8] = en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  state_t         state_r, state_s;
  logic [3:0]     wcnt_r;
  logic [IW-1:0]  idx_r;
  logic [NB-1:0]  be_r;
  logic           write_r, legal_r;
  logic [DW-1:0]  mem [0:DEPTH-1];

  logic           accept_s, range_ok_s, size_ok_s, align_ok_s, seq_ok_s, legal_s, commit_s;
  logic [31:0]    word_full_s;
  logic [AW-1:0]  align_mask_s;
  logic [IW-1:0]  new_idx_s, rd_idx_s;
  logic [LBW-1:0] new_lane_s;
  logic           rd_write_s, ready_s;
  logic [1:0]     resp_s;
  logic [DW-1:0]  rdata_s;

  // Address-phase decode: acceptance and legality of the presented transfer.
  always_comb begin
    accept_s     = hselect && hready && htrans[1] &&
                   ((state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2));
    word_full_s  = 32'(haddr) >> LB;
    range_ok_s   = word_full_s < 32'(DEPTH);
    size_ok_s    = 32'(hsize) <= 32'(LB);
    align_mask_s = (AW'(1'b1) << hsize) - AW'(1'b1);
    align_ok_s   = (haddr & align_mask_s) == {AW{1'b0}};
    legal_s      = range_ok_s && size_ok_s && align_ok_s && seq_ok_s;
    new_idx_s    = IW'(word_full_s);
    new_lane_s   = haddr[LBW-1:0] & LANE_MASK;
    commit_s     = (state_r == ST_DATA) && write_r && legal_r;
  end

`ifdef AHB_SLV_BURST_CHK_EN
  logic          ctx_r;
  logic [AW-1:0] exp_addr_r;
  logic [2:0]    exp_size_r, exp_burst_r;
  logic [AW-1:0] inc_s, wrap_mask_s, next_addr_s;
  logic [4:0]    wrap_shift_s;

  // Expected next beat address; WRAP bursts stay inside a beats*size window.
  always_comb begin
    inc_s        = AW'(1'b1) << hsize;
    // log2(beats) is hburst[2:1]+1 for WRAP4/8/16.
    wrap_shift_s = {3'b000, hburst[2:1]} + 5'd1 + {2'b00, hsize};
    wrap_mask_s  = (AW'(1'b1) << wrap_shift_s) - AW'(1'b1);
    if (!hburst[0] && (hburst != 3'b000)) begin
      next_addr_s = (haddr & ~wrap_mask_s) | ((haddr + inc_s) & wrap_mask_s);
    end else begin
      next_addr_s = haddr + inc_s;
    end
    if (htrans == 2'b11) begin
      seq_ok_s = ctx_r && (haddr == exp_addr_r) && (hsize == exp_size_r) && (hburst == exp_burst_r);
    end else begin
      seq_ok_s = 1'b1;
    end
  end

  // Burst context: set by each legal transfer, cleared by any ERROR.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctx_r       <= 1'b0;
      exp_addr_r  <= {AW{1'b0}};
      exp_size_r  <= 3'd0;
      exp_burst_r <= 3'd0;
    end else if (accept_s) begin
      if (legal_s) begin
        ctx_r       <= 1'b1;
        exp_addr_r  <= next_addr_s;
        exp_size_r  <= hsize;
        exp_burst_r <= hburst;
      end else begin
        ctx_r       <= 1'b0;
      end
    end
  end
`else
  assign seq_ok_s = 1'b1;
  logic unused_s;
  assign unused_s = ^{hburst, htrans[0]};
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          state_s = legal_s ? ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA) : ST_ERR1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_r == 4'd0) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ERR1: state_s = ST_ERR2;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next output values, decoded from the next state so the ports are registered.
  always_comb begin
    ready_s    = !((state_s == ST_WAIT) || (state_s == ST_ERR1));
    resp_s     = ((state_s == ST_ERR1) || (state_s == ST_ERR2)) ? 2'b01 : 2'b00;
    rd_idx_s   = accept_s ? new_idx_s : idx_r;
    rd_write_s = accept_s ? hwrite : write_r;
    if ((state_s == ST_DATA) && !rd_write_s) begin
      rdata_s = mem[rd_idx_s];
      // A write to the same word commits on this very edge; forward its lanes.
      if (commit_s && (idx_r == rd_idx_s)) begin
        rdata_s = merge_lanes(rdata_s, hwdata, be_r);
      end else begin
        rdata_s = rdata_s;
      end
    end else begin
      rdata_s = {DW{1'b0}};
    end
  end

  // State, transfer registers, wait counter and registered outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r   <= ST_IDLE;
      wcnt_r    <= 4'd0;
      idx_r     <= {IW{1'b0}};
      be_r      <= {NB{1'b0}};
      write_r   <= 1'b0;
      legal_r   <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= 2'b00;
      hrdata    <= {DW{1'b0}};
    end else begin
      state_r   <= state_s;
      hreadyout <= ready_s;
      hresp     <= resp_s;
      hrdata    <= rdata_s;
      if (accept_s) begin
        idx_r   <= new_idx_s;
        be_r    <= lane_enables(hsize, new_lane_s);
        write_r <= hwrite;
        legal_r <= legal_s;
      end
      if (accept_s && legal_s) begin
        wcnt_r <= WS_LOAD;
      end else if ((state_r == ST_WAIT) && (wcnt_r != 4'd0)) begin
        wcnt_r <= wcnt_r - 4'd1;
      end
    end
  end

  // Memory array (not reset): byte-lane write at the end of a write data phase.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      for (int i = 0; i < NB; i++) begin
        if (be_r[i]) begin
          mem[idx_r][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Testbench for ahb_slave_mem: one zero-wait instance (dut0) and one
// three-wait-state instance (dut1). A byte-addressed model predicts, per
// cycle, hreadyout/hresp/hrdata of each instance from the transfers the bench
// issues.
module tb_ahb_slave_mem;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] WRAP4  = 3'b010;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        hsel [2];
  logic        hrdy_force [2];
  logic [1:0]  htr [2];
  logic [15:0] ha [2];
  logic        hw [2];
  logic [2:0]  hsz [2];
  logic [2:0]  hbu [2];
  logic [31:0] hwd [2];
  logic        hrdy0, hrdy1, ro0, ro1;
  logic [1:0]  rs0, rs1;
  logic [31:0] rd0, rd1;

  assign hrdy0 = hrdy_force[0] ? 1'b0 : ro0;
  assign hrdy1 = hrdy_force[1] ? 1'b0 : ro1;

  ahb_slave_mem #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .hselect(hsel[0]), .hready(hrdy0), .htrans(htr[0]),
    .haddr(ha[0]), .hwrite(hw[0]), .hsize(hsz[0]), .hburst(hbu[0]), .hwdata(hwd[0]),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));

  ahb_slave_mem #(.AW(16), .DW(32), .DEPTH(1024), .WAIT_STATES(3)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .hselect(hsel[1]), .hready(hrdy1), .htrans(htr[1]),
    .haddr(ha[1]), .hwrite(hw[1]), .hsize(hsz[1]), .hburst(hbu[1]), .hwdata(hwd[1]),
    .hreadyout(ro1), .hresp(rs1), .hrdata(rd1));

  typedef struct {
    logic        rdy;
    logic [1:0]  resp;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
  } exp_t;

  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [7:0]  mm [int];
  int          checks = 0;
  int          errors = 0;
  bit          run_cmp = 1'b0;
  logic [31:0] last_rd [2];
  int          lowcnt [2];
  int          errcyc [2];
  logic [31:0] pend_wd [2];
  bit          ctx_v [2];
  logic [15:0] exp_a [2];
  logic [2:0]  exp_sz [2];
  logic [2:0]  exp_bu [2];
  int          ws [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_exp(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Model of one accepted transfer: the data-phase cycles it must produce.
  task automatic model_accept(input int k, input logic [1:0] tr, input logic [15:0] a, input logic w,
                              input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd);
    int   bytes;
    int   span;
    bit   legal;
    exp_t e;
    bytes = 1 << sz;
    legal = ((int'(a) / 4) < 1024) && (sz <= 3'd2) && ((int'(a) % bytes) == 0);
`ifdef AHB_SLV_BURST_CHK_EN
    if (tr == SEQ && !(ctx_v[k] && a == exp_a[k] && sz == exp_sz[k] && bu == exp_bu[k])) legal = 1'b0;
    if (legal) begin
      ctx_v[k]  = 1'b1;
      exp_sz[k] = sz;
      exp_bu[k] = bu;
      if (bu == 3'd2 || bu == 3'd4 || bu == 3'd6) begin
        span     = (2 << (bu >> 1)) * bytes;
        exp_a[k] = 16'((int'(a) / span) * span + (int'(a) + bytes) % span);
      end else begin
        exp_a[k] = 16'(int'(a) + bytes);
      end
    end else begin
      ctx_v[k] = 1'b0;
    end
`else
    if (tr == SEQ && bu == 3'd7) legal = legal;
`endif
    e = '{rdy: 1'b0, resp: 2'b00, rd: 1'b0, wr: 1'b0, a: a, sz: sz, wd: wd};
    if (legal) begin
      for (int n = 0; n < ws[k]; n++) push_exp(k, e);
      e.rdy = 1'b1;
      e.rd  = !w;
      e.wr  = w;
      push_exp(k, e);
    end else begin
      e.resp = 2'b01;
      push_exp(k, e);
      e.rdy = 1'b1;
      push_exp(k, e);
    end
  endtask

  // Compare one instance's outputs for the current cycle against the model.
  task automatic cmp_cycle(input int k, input logic ro, input logic [1:0] rs, input logic [31:0] rd);
    exp_t        e;
    logic [31:0] xd;
    int          kb;
    int          b;
    int          ad;
    e  = '{rdy: 1'b1, resp: 2'b00, rd: 1'b0, wr: 1'b0, a: 16'h0, sz: 3'd0, wd: 32'h0};
    kb = k * 65536;
    if (k == 0 && q0.size() > 0) e = q0.pop_front();
    else if (k == 1 && q1.size() > 0) e = q1.pop_front();
    xd = 32'h0;
    if (e.rd) begin
      b  = (int'(e.a) / 4) * 4;
      xd = {mm[kb+b+3], mm[kb+b+2], mm[kb+b+1], mm[kb+b]};
      last_rd[k] = rd;
    end
    if (e.wr) begin
      for (int i = 0; i < (1 << e.sz); i++) begin
        ad = int'(e.a) + i;
        mm[kb+ad] = e.wd[8*(ad%4) +: 8];
      end
    end
    check($sformatf("dut%0d_hreadyout", k), 32'(ro), 32'(e.rdy));
    check($sformatf("dut%0d_hresp", k), 32'(rs), 32'(e.resp));
    check($sformatf("dut%0d_hrdata", k), rd, xd);
    if (!ro) lowcnt[k]++;
    if (rs == 2'b01) errcyc[k]++;
  endtask

  // Per-cycle compare of both instances.
  always @(negedge HCLK) begin
    if (run_cmp && !HRESET) begin
      cmp_cycle(0, ro0, rs0, rd0);
      cmp_cycle(1, ro1, rs1, rd1);
    end
  end

  function automatic logic hrdy_now(input int k);
    return (k == 0) ? hrdy0 : hrdy1;
  endfunction

  // Present an address phase (and the previous data phase's write data),
  // hold it until hready, then hand the accepted transfer to the model.
  task automatic bus(input int k, input logic [1:0] tr, input logic [15:0] a, input logic w,
                     input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd);
    int n;
    hsel[k] = tr[1];
    htr[k]  = tr;
    ha[k]   = a;
    hw[k]   = w;
    hsz[k]  = sz;
    hbu[k]  = bu;
    hwd[k]  = pend_wd[k];
    n = 0;
    while (hrdy_now(k) == 1'b0 && n < 40) begin
      @(posedge HCLK); #1;
      n++;
    end
    check($sformatf("dut%0d_wait_bound", k), 32'(n < 40), 32'h1);
    @(posedge HCLK); #1;
    if (tr[1]) model_accept(k, tr, a, w, sz, bu, wd);
    pend_wd[k] = w ? wd : 32'h0;
  endtask

  task automatic idle(input int k);
    bus(k, IDLE, 16'h0, 1'b0, 3'd2, SINGLE, 32'h0);
  endtask

  initial begin
    ws[0] = 0;
    ws[1] = 3;
    for (int k = 0; k < 2; k++) begin
      hsel[k] = 1'b0; hrdy_force[k] = 1'b0; htr[k] = IDLE; ha[k] = 16'h0; hw[k] = 1'b0;
      hsz[k] = 3'd0; hbu[k] = SINGLE; hwd[k] = 32'h0; pend_wd[k] = 32'h0; ctx_v[k] = 1'b0;
      exp_a[k] = 16'h0; exp_sz[k] = 3'd0; exp_bu[k] = 3'd0; last_rd[k] = 32'h0;
      lowcnt[k] = 0; errcyc[k] = 0;
    end
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    check("reset_hreadyout0", 32'(ro0), 32'h1);
    check("reset_hresp0", 32'(rs0), 32'h0);
    check("reset_hrdata0", rd0, 32'h0);
    check("reset_hreadyout1", 32'(ro1), 32'h1);
    check("reset_hresp1", 32'(rs1), 32'h0);
    check("reset_hrdata1", rd1, 32'h0);
    HRESET  = 1'b0;
    run_cmp = 1'b1;

    // Zero-wait write then back-to-back read of the same word.
    bus(0, NONSEQ, 16'h0010, 1'b1, 3'd2, SINGLE, 32'hDEADBEEF);
    bus(0, NONSEQ, 16'h0010, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(0);
    check("lit_rd_deadbeef", last_rd[0], 32'hDEADBEEF);

    // Byte write to lane 3, then word read.
    bus(0, NONSEQ, 16'h0013, 1'b1, 3'd0, SINGLE, 32'hAA000000);
    bus(0, NONSEQ, 16'h0010, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(0);
    check("lit_rd_byte_lane", last_rd[0], 32'hAAADBEEF);

    // Address phase with hready low must be ignored.
    hrdy_force[0] = 1'b1; hsel[0] = 1'b1; htr[0] = NONSEQ; ha[0] = 16'h0010;
    hw[0] = 1'b1; hsz[0] = 3'd2; hbu[0] = SINGLE; hwd[0] = 32'h0;
    @(posedge HCLK); #1;
    hrdy_force[0] = 1'b0; htr[0] = IDLE; hsel[0] = 1'b0; hwd[0] = 32'h55555555;
    @(posedge HCLK); #1;
    bus(0, NONSEQ, 16'h0010, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(0);
    check("lit_rd_hready_low", last_rd[0], 32'hAAADBEEF);

    // Illegal accesses: out of range, misaligned, oversize.
    errcyc[0] = 0;
    bus(0, NONSEQ, 16'h0000, 1'b1, 3'd2, SINGLE, 32'h01234567);
    bus(0, NONSEQ, 16'h1000, 1'b0, 3'd2, SINGLE, 32'h0);
    bus(0, NONSEQ, 16'h0002, 1'b1, 3'd2, SINGLE, 32'h11111111);
    bus(0, NONSEQ, 16'h0010, 1'b1, 3'd3, SINGLE, 32'h22222222);
    idle(0);
    check("lit_err_cycles", 32'(errcyc[0]), 32'd6);
    bus(0, NONSEQ, 16'h0000, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(0);
    check("lit_rd_after_err0", last_rd[0], 32'h01234567);
    bus(0, NONSEQ, 16'h0010, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(0);
    check("lit_rd_after_err1", last_rd[0], 32'hAAADBEEF);

    // WRAP4 word burst, then a burst broken by a SEQ at 0x0040.
    bus(0, NONSEQ, 16'h0038, 1'b1, 3'd2, WRAP4, 32'h0A0A0A38);
    bus(0, SEQ,    16'h003C, 1'b1, 3'd2, WRAP4, 32'h0A0A0A3C);
    bus(0, SEQ,    16'h0030, 1'b1, 3'd2, WRAP4, 32'h0A0A0A30);
    bus(0, SEQ,    16'h0034, 1'b1, 3'd2, WRAP4, 32'h0A0A0A34);
    bus(0, NONSEQ, 16'h0038, 1'b1, 3'd2, WRAP4, 32'hB0B0B038);
    bus(0, SEQ,    16'h003C, 1'b1, 3'd2, WRAP4, 32'hB0B0B03C);
    bus(0, SEQ,    16'h0040, 1'b1, 3'd2, WRAP4, 32'hB0B0B040);
    idle(0);
    bus(0, NONSEQ, 16'h0030, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(0);
    check("lit_rd_wrap", last_rd[0], 32'h0A0A0A30);
`ifdef AHB_SLV_BURST_CHK_EN
    check("lit_err_cycles_burst", 32'(errcyc[0]), 32'd8);
`else
    check("lit_err_cycles_burst", 32'(errcyc[0]), 32'd6);
`endif

    // Three wait states on a single read.
    bus(1, NONSEQ, 16'h0020, 1'b1, 3'd2, SINGLE, 32'hCAFEF00D);
    idle(1);
    lowcnt[1] = 0;
    bus(1, NONSEQ, 16'h0020, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(1);
    check("lit_wait_cycles", 32'(lowcnt[1]), 32'd3);
    check("lit_rd_ws3", last_rd[1], 32'hCAFEF00D);

    // Reset during a wait cycle of a write: write discarded.
    bus(1, NONSEQ, 16'h0020, 1'b1, 3'd2, SINGLE, 32'h12345678);
    htr[1] = IDLE; hsel[1] = 1'b0; hwd[1] = 32'h12345678;
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    check("rst_mid_hreadyout", 32'(ro1), 32'h1);
    check("rst_mid_hresp", 32'(rs1), 32'h0);
    check("rst_mid_hrdata", rd1, 32'h0);
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      ctx_v[k] = 1'b0;
      pend_wd[k] = 32'h0;
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    bus(1, NONSEQ, 16'h0020, 1'b0, 3'd2, SINGLE, 32'h0);
    idle(1);
    check("lit_rd_after_reset", last_rd[1], 32'hCAFEF00D);

    repeat (2) @(posedge HCLK);
    #1;
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Parametrised AHB slave memory model with configurable data width, depth and wait states, used as the target device in the AHB verification environment. It accepts pipelined address/data-phase transfers from the master interface, supports byte/halfword/word sizes with byte-lane writes, inserts programmable wait states, and returns the two-cycle ERROR response for illegal accesses. It sits on the slave side of the AHB bus and is driven by the decoder's select line.

## Interface
- AW, 16: address width in bits.
- DW, 32: data width in bits; one of 8, 16, 32 or 64.
- DEPTH, 1024: memory depth in DW-bit words.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase; 0–15.

- HCLK  in  1  bus clock; all state changes on the rising edge.
- HRESET  in  1  reset; asynchronous, active-high.
- hselect  in  1  slave select from the decoder.
- hready  in  1  bus-wide ready; the address phase is accepted only when it is high.
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- haddr  in  AW  byte address.
- hwrite  in  1  1 for write, 0 for read.
- hsize  in  3  transfer size, log2 of the byte count.
- hburst  in  3  burst type: 000 SINGLE, 001 INCR, 010/100/110 WRAP4/8/16, 011/101/111 INCR4/8/16.
- hwdata  in  DW  write data, valid in the data phase.
- hreadyout  out  1  slave ready; low extends the data phase.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  DW  read data.

## Operation
- Address-phase accept: rising edge with hselect & hready & htrans[1]. The block registers haddr, hwrite and hsize, plus a legality flag.
- Illegal access, any of:
  - word index haddr>>log2(DW/8) ≥ DEPTH;
  - hsize > log2(DW/8);
  - haddr not aligned to 1<<hsize.
- IDLE/BUSY or unselected: no transfer; the next data phase is zero-wait OKAY.
- State machine:
  - IDLE: hreadyout=1, hresp=00. An accepted legal transfer goes to WAIT if WAIT_STATES>0, otherwise DATA. An illegal transfer goes to ERR1.
  - WAIT: hreadyout=0, hresp=00. A counter loads WAIT_STATES−1 and decrements; at 0 the block goes to DATA.
  - DATA: hreadyout=1, hresp=00; the transfer completes this cycle. A new accept in the same cycle re-enters WAIT/DATA/ERR1, otherwise the block returns to IDLE.
  - ERR1: hreadyout=0, hresp=01, for one cycle, then ERR2.
  - ERR2: hreadyout=1, hresp=01, for one cycle. A new address accepted in this cycle is processed normally.
- Write commit: at the DATA-cycle edge, only the addressed byte lanes are written from the matching hwdata lanes. Lanes are little-endian, with lane index = haddr[log2(DW/8)-1:0].
- Read:
  - hrdata = mem[registered word index] during DATA when the registered hwrite is 0.
  - hrdata = 0 in all other cycles.
  - The full word is driven; the master selects the lanes.
- The memory array is not reset. ERROR transfers never modify memory.

## Timing
- Reset values: hreadyout=1, hresp=00, hrdata=0, state IDLE, wait counter 0.
- Latency: a data phase lasts WAIT_STATES+1 cycles for OKAY and exactly 2 cycles for ERROR.
- With WAIT_STATES=0, back-to-back NONSEQ/SEQ transfers complete one per cycle.
- Read after write to the same address, back-to-back: the read returns the new data, because the write commits on the edge that starts the read's data phase.
- HRESET asserted mid-transfer: the block returns to IDLE immediately with reset output values. A pending write is discarded.
- When hready is low, the address phase is ignored even if hselect=1.

## Configuration
- AHB_SLV_BURST_CHK_EN defined: the block tracks the expected next address from the last accepted transfer.
  - INCR types: expected address = previous + (1<<hsize).
  - WRAP4/8/16 types: the increment wraps within a boundary of (beats × (1<<hsize)) bytes.
  - A SEQ transfer whose haddr, hsize or hburst mismatches, or that has no preceding NONSEQ/SEQ, takes the ERROR path.
  - An ERROR response clears the burst context.
- AHB_SLV_BURST_CHK_EN undefined: SEQ is treated identically to NONSEQ and no burst tracking is present.

## Test plan
- WAIT_STATES=0, DW=32: NONSEQ write 0xDEADBEEF to 0x0010, hsize=2, then read 0x0010 -> zero-wait OKAY for both; the read data phase shows hrdata=0xDEADBEEF.
- Byte write 0xAA to 0x0013, hsize=0, hwdata=0xAA000000 -> a subsequent word read of 0x0010 returns 0xAAADBEEF.
- WAIT_STATES=3: single read -> hreadyout low for exactly 3 cycles, then high with hresp=00.
- Illegal accesses -> for each: ERR1 (hreadyout=0, hresp=01), then ERR2 (hreadyout=1, hresp=01); memory unchanged.
  - Read of 0x1000 with DEPTH=1024.
  - hsize=2 at 0x0002.
  - hsize=3 with DW=32.
- With AHB_SLV_BURST_CHK_EN: WRAP4 word burst from 0x0038 -> SEQ beats at 0x003C, 0x0030, 0x0034 all OKAY; a SEQ at 0x0040 in place of 0x0030 -> ERROR.
- HRESET pulsed during a WAIT cycle of a write to 0x0020 -> outputs return to reset values at once; a later read of 0x0020 returns the previous contents.
